inst_fetch_unit: RTL and testbench

Parametrised successor to the single-register IF stage. Generates sequential fetch addresses and runs a ready-qualified request handshake with instruction memory. Buffers returned instructions with their PCs in a small FIFO and presents them to decode through a valid/ready interface. Supports branch/jump redirect with buffer flush, memory wait states and downstream back-pressure.

---
 rtl/inst_fetch_unit.sv | 105 ++++++++++
 tb/tb_inst_fetch_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, ready-qualified memory request,
// and a small PC/instruction buffer feeding decode over valid/ready, with redirect flush.
module inst_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4,
    parameter int                    FIFO_DEPTH = 4,
    localparam int                   CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] inst_address,
    output logic                  InstMem_Read,
    input  logic [DATA_WIDTH-1:0] inst_in,
    input  logic                  InstMem_Ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_pc_next,
    output logic [CW-1:0]         buf_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, FULL} state_t;

    state_t                               state_q, state_d;
    logic [ADDR_WIDTH-1:0]                pc_q, pc_d;
    logic [CW-1:0]                        count_q, count_d;
    logic [PW-1:0]                        wr_q, rd_q;
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] inst_q;
    logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] pcbuf_q;
    logic                                 push, pop;

    // Redirect cycles never request, so a response arriving alongside a redirect is never pushed.
    assign InstMem_Read = (state_q == RUN) && fetch_en && (count_q < FULL_CNT) && !redirect_valid;
    assign inst_address = pc_q;
    assign push         = InstMem_Read && InstMem_Ready;
    assign out_valid    = (count_q != '0);
    assign pop          = out_valid && out_ready;
    assign out_inst     = inst_q[rd_q];
    assign out_pc       = pcbuf_q[rd_q];
    assign out_pc_next  = out_pc + ADDR_WIDTH'(PC_STEP);
    assign buf_count    = count_q;

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            count_d = '0;
        end else begin
            if (push) pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (count_d == FULL_CNT) state_d = FULL;
            FULL:    if (pop) state_d = RUN;
            default: state_d = BOOT;
        endcase
        if (redirect_valid && state_q != BOOT) state_d = RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            inst_q  <= '0;
            pcbuf_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            if (redirect_valid) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) begin
                    inst_q[wr_q]  <= inst_in;
                    pcbuf_q[wr_q] <= pc_q;
                    wr_q          <= wr_q + PW'(1);
                end
                if (pop) rd_q <= rd_q + PW'(1);
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst) count_q <= FULL_CNT);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: boot, streaming, back-pressure, wait states,
// redirect flush, PC wrap and asynchronous reset mid-request.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en, redirect_valid, InstMem_Read, InstMem_Ready;
    logic        out_valid, out_ready;
    logic [31:0] redirect_pc, inst_address, inst_in, out_inst, out_pc, out_pc_next;
    logic [2:0]  buf_count;
    int          n_cmp = 0;
    int          n_err = 0;

    inst_fetch_unit dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_address(inst_address), .InstMem_Read(InstMem_Read),
        .inst_in(inst_in), .InstMem_Ready(InstMem_Ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_pc_next(out_pc_next), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Leaves the bench 1ns after the edge that moves BOOT -> RUN, PC=0, buffer empty.
    task automatic do_reset();
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_in = '0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; fetch_en = 1'b1; InstMem_Ready = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; inst_in = '0;
        tick(); tick(); tick();
        n_cmp++; if (InstMem_Read !== 1'b0) begin n_err++; $display("FAIL rst_read got %0b want 0", InstMem_Read); end
        n_cmp++; if (buf_count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", buf_count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", out_valid); end
        n_cmp++; if (inst_address !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", inst_address); end
        n_cmp++; if (out_inst !== 32'h0 || out_pc !== 32'h0) begin n_err++; $display("FAIL rst_head got %h/%h want 0/0", out_inst, out_pc); end
        rst = 1'b1; #1;
        n_cmp++; if (InstMem_Read !== 1'b0) begin n_err++; $display("FAIL boot_read got %0b want 0", InstMem_Read); end
        tick();
        n_cmp++; if (InstMem_Read !== 1'b1 || inst_address !== 32'h0) begin n_err++; $display("FAIL run_first got %0b/%h want 1/0", InstMem_Read, inst_address); end
    endtask

    task automatic test_stream();
        do_reset();
        fetch_en = 1'b1; InstMem_Ready = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            inst_in = 32'hA0 + k; #1;
            n_cmp++; if (InstMem_Read !== 1'b1 || inst_address !== 32'(4*k)) begin n_err++; $display("FAIL stream_req%0d got %0b/%h want 1/%h", k, InstMem_Read, inst_address, 4*k); end
            if (k == 0) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_v0 got %0b want 0", out_valid); end
            end else begin
                n_cmp++; if (out_valid !== 1'b1 || out_inst !== 32'(32'hA0 + k - 1)) begin n_err++; $display("FAIL stream_inst%0d got %0b/%h want 1/%h", k, out_valid, out_inst, 32'hA0 + k - 1); end
                n_cmp++; if (out_pc !== 32'(4*(k-1)) || out_pc_next !== 32'(4*k)) begin n_err++; $display("FAIL stream_pc%0d got %h/%h want %h/%h", k, out_pc, out_pc_next, 4*(k-1), 4*k); end
                n_cmp++; if (buf_count !== 3'd1) begin n_err++; $display("FAIL stream_cnt%0d got %0d want 1", k, buf_count); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_en = 1'b1; InstMem_Ready = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            inst_in = 32'hB0 + k;
            tick();
        end
        #1;
        n_cmp++; if (buf_count !== 3'd4) begin n_err++; $display("FAIL bp_count got %0d want 4", buf_count); end
        n_cmp++; if (InstMem_Read !== 1'b0 || inst_address !== 32'h10) begin n_err++; $display("FAIL bp_stall got %0b/%h want 0/10", InstMem_Read, inst_address); end
        n_cmp++; if (out_inst !== 32'hB0 || out_pc !== 32'h0) begin n_err++; $display("FAIL bp_head got %h/%h want b0/0", out_inst, out_pc); end
        tick();
        n_cmp++; if (buf_count !== 3'd4 || InstMem_Read !== 1'b0) begin n_err++; $display("FAIL bp_hold got %0d/%0b want 4/0", buf_count, InstMem_Read); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; #1;
        n_cmp++; if (InstMem_Read !== 1'b1 || inst_address !== 32'h10) begin n_err++; $display("FAIL bp_resume got %0b/%h want 1/10", InstMem_Read, inst_address); end
        n_cmp++; if (buf_count !== 3'd3 || out_inst !== 32'hB1 || out_pc !== 32'h4) begin n_err++; $display("FAIL bp_pop got %0d/%h/%h want 3/b1/4", buf_count, out_inst, out_pc); end
    endtask

    task automatic test_wait_states();
        do_reset();
        fetch_en = 1'b1; InstMem_Ready = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (InstMem_Read !== 1'b1 || inst_address !== 32'h0 || buf_count !== 3'd0) begin n_err++; $display("FAIL ws_wait%0d got %0b/%h/%0d want 1/0/0", k, InstMem_Read, inst_address, buf_count); end
            tick();
        end
        InstMem_Ready = 1'b1; inst_in = 32'hC0;
        tick();
        InstMem_Ready = 1'b0; #1;
        n_cmp++; if (buf_count !== 3'd1 || out_inst !== 32'hC0 || inst_address !== 32'h4) begin n_err++; $display("FAIL ws_push got %0d/%h/%h want 1/c0/4", buf_count, out_inst, inst_address); end
        fetch_en = 1'b0; #1;
        n_cmp++; if (InstMem_Read !== 1'b0) begin n_err++; $display("FAIL ws_withdraw got %0b want 0", InstMem_Read); end
        InstMem_Ready = 1'b1;
        tick();
        n_cmp++; if (buf_count !== 3'd1 || inst_address !== 32'h4) begin n_err++; $display("FAIL ws_ignore got %0d/%h want 1/4", buf_count, inst_address); end
        fetch_en = 1'b1; InstMem_Ready = 1'b0; #1;
        n_cmp++; if (InstMem_Read !== 1'b1 || inst_address !== 32'h4) begin n_err++; $display("FAIL ws_reissue got %0b/%h want 1/4", InstMem_Read, inst_address); end
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_en = 1'b1; InstMem_Ready = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            inst_in = 32'hD0 + k;
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h103; inst_in = 32'hDEAD; #1;
        n_cmp++; if (buf_count !== 3'd3 || InstMem_Read !== 1'b0) begin n_err++; $display("FAIL rd_pre got %0d/%0b want 3/0", buf_count, InstMem_Read); end
        tick();
        redirect_valid = 1'b0; InstMem_Ready = 1'b0; #1;
        n_cmp++; if (buf_count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rd_flush got %0d/%0b want 0/0", buf_count, out_valid); end
        n_cmp++; if (inst_address !== 32'h100) begin n_err++; $display("FAIL rd_addr got %h want 100", inst_address); end
        InstMem_Ready = 1'b1; inst_in = 32'hE0;
        tick();
        InstMem_Ready = 1'b0; #1;
        n_cmp++; if (out_valid !== 1'b1 || out_inst !== 32'hE0 || out_pc !== 32'h100 || out_pc_next !== 32'h104) begin n_err++; $display("FAIL rd_target got %0b/%h/%h/%h want 1/e0/100/104", out_valid, out_inst, out_pc, out_pc_next); end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h305;
        tick();
        redirect_valid = 1'b0; #1;
        n_cmp++; if (inst_address !== 32'h304 || buf_count !== 3'd0) begin n_err++; $display("FAIL rd_b2b got %h/%0d want 304/0", inst_address, buf_count); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        fetch_en = 1'b1; InstMem_Ready = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0; InstMem_Ready = 1'b1; inst_in = 32'hF0; #1;
        n_cmp++; if (InstMem_Read !== 1'b1 || inst_address !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_req got %0b/%h want 1/fffffffc", InstMem_Read, inst_address); end
        tick();
        InstMem_Ready = 1'b0; #1;
        n_cmp++; if (inst_address !== 32'h0) begin n_err++; $display("FAIL wrap_addr got %h want 0", inst_address); end
        n_cmp++; if (out_pc !== 32'hFFFF_FFFC || out_pc_next !== 32'h0 || out_inst !== 32'hF0) begin n_err++; $display("FAIL wrap_head got %h/%h/%h want fffffffc/0/f0", out_pc, out_pc_next, out_inst); end
        tick();
        n_cmp++; if (InstMem_Read !== 1'b1 || inst_address !== 32'h0) begin n_err++; $display("FAIL mid_pre got %0b/%h want 1/0", InstMem_Read, inst_address); end
        #2 rst = 1'b0; #1;
        n_cmp++; if (InstMem_Read !== 1'b0 || buf_count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst got %0b/%0d/%0b want 0/0/0", InstMem_Read, buf_count, out_valid); end
        n_cmp++; if (inst_address !== 32'h0 || out_pc !== 32'h0) begin n_err++; $display("FAIL mid_pc got %h/%h want 0/0", inst_address, out_pc); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_wait_states();
        test_redirect();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
